// File: rtl/div_by_const_serial.sv
// Unsigned divide by a constant, DIGIT_BITS dividend bits per cycle via a (rem, digit) lookup table.
// Latency: out_valid rises N = DATA_WIDTH/DIGIT_BITS cycles after the accept edge.
// Backpressure: one operation in flight; results held in DONE until out_ready, in_ready low meanwhile.
module div_by_const_serial #(
    parameter int DATA_WIDTH = 20,
    parameter int DIVISOR    = 3,
    parameter int DIGIT_BITS = 2,
    localparam int REM_W     = $clog2(DIVISOR)
) (
    input  logic                  sys_clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [REM_W-1:0]      remainder
);

    localparam int N        = DATA_WIDTH / DIGIT_BITS;
    localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W    = REM_W + DIGIT_BITS;
    localparam int LUT_SIZE = 1 << IDX_W;

    if ((DATA_WIDTH % DIGIT_BITS) != 0 || DIVISOR < 2 || DIGIT_BITS < 1 || DIGIT_BITS > 4)
    begin : g_bad_params
        $error("div_by_const_serial: illegal DATA_WIDTH/DIVISOR/DIGIT_BITS combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] qacc;
    logic [DATA_WIDTH-1:0] q_nxt;
    logic [REM_W-1:0]      rem;
    logic [REM_W-1:0]      rem_nxt;
    logic [CNT_W-1:0]      count;
    logic [IDX_W-1:0]      lut_idx;
    logic [DIGIT_BITS-1:0] qdigit;
    logic                  accept;
    logic                  last_iter;

    // Table index equals t = rem*2^DIGIT_BITS + digit; rows with rem >= DIVISOR never occur.
    logic [DIGIT_BITS-1:0] lut_q [LUT_SIZE];
    logic [REM_W-1:0]      lut_r [LUT_SIZE];

    for (genvar i = 0; i < LUT_SIZE; i++) begin : g_lut
        localparam bit LIVE = (i >> DIGIT_BITS) < DIVISOR;
        localparam int QV   = LIVE ? (i / DIVISOR) : 0;
        localparam int RV   = LIVE ? (i % DIVISOR) : 0;
        assign lut_q[i] = DIGIT_BITS'(QV);
        assign lut_r[i] = REM_W'(RV);
    end

    assign lut_idx   = {rem, shreg[DATA_WIDTH-1 -: DIGIT_BITS]};
    assign qdigit    = lut_q[lut_idx];
    assign rem_nxt   = lut_r[lut_idx];
    assign q_nxt     = (qacc << DIGIT_BITS) | DATA_WIDTH'(qdigit);
    assign accept    = (state == IDLE) && in_valid;
    assign last_iter = (count == CNT_W'(N - 1));

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            qacc      <= '0;
            rem       <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            shreg <= dividend;
            qacc  <= '0;
            rem   <= '0;
            count <= '0;
        end else if (state == RUN) begin
            shreg <= shreg << DIGIT_BITS;
            qacc  <= q_nxt;
            rem   <= rem_nxt;
            count <= count + CNT_W'(1);
            // Result registers change only on the edge entering DONE.
            if (last_iter) begin
                quotient  <= q_nxt;
                remainder <= rem_nxt;
            end
        end
    end

endmodule
